// File: rtl/mono_switch_pkg.sv
// Shared state encoding, mono mode codes and gain constants for the mono switch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mono_switch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        SWITCH,
        FADE_IN,
        WAIT_VB
    } state_t;

    localparam logic [2:0] MONO_COLOR = 3'd0;
    localparam logic [2:0] MONO_GREEN = 3'd1;
    localparam logic [2:0] MONO_AMBER = 3'd2;
    localparam logic [2:0] MONO_BLUE  = 3'd3;
    localparam logic [2:0] MONO_GREY  = 3'd4;

    localparam logic [7:0] GAIN_UNITY = 8'hFF;

endpackage

// File: rtl/frame_tick.sv
// Frame tick: pulses on the first ce_pix-qualified sample where VBlank_in is high after being low.
// Latency: combinational from the qualifying sample.
// Backpressure: none; the tick is a free-running timing strobe.
module frame_tick (
    input  logic clk_vid,
    input  logic reset,
    input  logic ce_pix,
    input  logic VBlank_in,
    output logic tick
);

    // Reset value of 1 suppresses a spurious tick when released inside blanking.
    logic vb_prev;

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            vb_prev <= 1'b1;
        end else if (ce_pix) begin
            vb_prev <= VBlank_in;
        end
    end

    assign tick = ce_pix & VBlank_in & ~vb_prev;

endmodule

// File: rtl/mono_switch_ctrl.sv
// Mono mode switch: fades gain out, swaps mono on a dark frame, fades back in (MONO_SWITCH_FADE_EN); else swaps on next frame tick.
// Latency: ack one cycle after a same-mode request, otherwise on the frame tick that completes the switch.
// Backpressure: none; requests arriving while busy or during ack land in a one-deep last-writer-wins pending slot.
module mono_switch_ctrl
    import mono_switch_pkg::*;
#(
    parameter logic [7:0] FADE_STEP = 8'd32
) (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       VBlank_in,
    input  logic       req,
    input  logic [2:0] req_mode,
    output logic [2:0] mono,
    output logic [7:0] gain,
    output logic       busy,
    output logic       ack
);

    state_t     state, state_nxt;
    logic [2:0] mono_nxt, target, target_nxt, pend_mode, pend_mode_nxt, new_mode;
    logic       busy_nxt, ack_nxt, pend_vld, pend_vld_nxt, new_vld, tick;

    frame_tick u_frame_tick (
        .clk_vid  (clk_vid),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .VBlank_in(VBlank_in),
        .tick     (tick)
    );

`ifdef MONO_SWITCH_FADE_EN
    logic [7:0] gain_nxt;
    logic [8:0] gain_up;
    assign gain_up = {1'b0, gain} + {1'b0, FADE_STEP};
`else
    logic fade_step_unused;
    assign fade_step_unused = ^FADE_STEP;
    assign gain = GAIN_UNITY;
`endif

    always_comb begin
        state_nxt     = state;
        mono_nxt      = mono;
        busy_nxt      = busy;
        ack_nxt       = 1'b0;
        target_nxt    = target;
        pend_vld_nxt  = pend_vld;
        pend_mode_nxt = pend_mode;
        new_vld       = 1'b0;
        new_mode      = req_mode;
`ifdef MONO_SWITCH_FADE_EN
        gain_nxt      = gain;
`endif

        // A parked request outranks a fresh one; the fresh one is parked in its place.
        if (state == IDLE && !ack) begin
            if (pend_vld) begin
                new_vld      = 1'b1;
                new_mode     = pend_mode;
                pend_vld_nxt = req;
                if (req) pend_mode_nxt = req_mode;
            end else if (req) begin
                new_vld = 1'b1;
            end
        end else if (req) begin
            pend_vld_nxt  = 1'b1;
            pend_mode_nxt = req_mode;
        end

        case (state)
            IDLE: begin
                if (new_vld) begin
                    if (new_mode == mono) begin
                        ack_nxt = 1'b1;
                    end else begin
                        target_nxt = new_mode;
                        busy_nxt   = 1'b1;
`ifdef MONO_SWITCH_FADE_EN
                        state_nxt  = FADE_OUT;
`else
                        state_nxt  = WAIT_VB;
`endif
                    end
                end
            end
`ifdef MONO_SWITCH_FADE_EN
            FADE_OUT: begin
                if (tick) begin
                    if (gain <= FADE_STEP) begin
                        gain_nxt  = 8'd0;
                        state_nxt = SWITCH;
                    end else begin
                        gain_nxt = gain - FADE_STEP;
                    end
                end
            end
            SWITCH: begin
                mono_nxt  = target;
                state_nxt = FADE_IN;
            end
            FADE_IN: begin
                if (tick) begin
                    if (gain_up >= {1'b0, GAIN_UNITY}) begin
                        gain_nxt  = GAIN_UNITY;
                        ack_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        gain_nxt = gain_up[7:0];
                    end
                end
            end
`else
            WAIT_VB: begin
                if (tick) begin
                    mono_nxt  = target;
                    ack_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mono      <= MONO_COLOR;
            busy      <= 1'b0;
            ack       <= 1'b0;
            target    <= MONO_COLOR;
            pend_vld  <= 1'b0;
            pend_mode <= MONO_COLOR;
`ifdef MONO_SWITCH_FADE_EN
            gain      <= GAIN_UNITY;
`endif
        end else begin
            state     <= state_nxt;
            mono      <= mono_nxt;
            busy      <= busy_nxt;
            ack       <= ack_nxt;
            target    <= target_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_mode <= pend_mode_nxt;
`ifdef MONO_SWITCH_FADE_EN
            gain      <= gain_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mono_switch_ctrl.sv
// Self-checking bench for mono_switch_ctrl: directed scenarios plus a randomized run against a frame-level model.
// Works with or without MONO_SWITCH_FADE_EN; FADE_STEP is fixed at 64.
module tb_mono_switch_ctrl;

    localparam logic [7:0] STEP   = 8'd64;
    localparam int         STEP_I = 64;

    logic       clk_vid   = 1'b0;
    logic       reset     = 1'b0;
    logic       ce_pix    = 1'b0;
    logic       VBlank_in = 1'b0;
    logic       req       = 1'b0;
    logic [2:0] req_mode  = 3'd0;
    logic [2:0] mono;
    logic [7:0] gain;
    logic       busy, ack;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] cur    = 3'd0;

    mono_switch_ctrl #(.FADE_STEP(STEP)) dut (
        .clk_vid  (clk_vid),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .VBlank_in(VBlank_in),
        .req      (req),
        .req_mode (req_mode),
        .mono     (mono),
        .gain     (gain),
        .busy     (busy),
        .ack      (ack)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic cyc(input logic c, input logic v, input logic r, input logic [2:0] m);
        ce_pix    = c;
        VBlank_in = v;
        req       = r;
        req_mode  = m;
        @(posedge clk_vid);
        #1;
        req = 1'b0;
    endtask

    task automatic run_to_ack(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            cyc(1'b1, (i % 4) == 3, 1'b0, 3'd0);
            got = ack;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mono, gain, busy, ack} !== {3'd0, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: mono=%0d gain=%h busy=%b ack=%b, want 0 ff 0 0", mono, gain, busy, ack);
        end
        @(posedge clk_vid);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if ({mono, gain, busy, ack} !== {3'd0, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: mono=%0d gain=%h busy=%b ack=%b, want 0 ff 0 0", mono, gain, busy, ack);
        end
    endtask

    task automatic test_mode_change();
        int e;
`ifdef MONO_SWITCH_FADE_EN
        cyc(1'b1, 1'b0, 1'b1, 3'd1);
        checks++;
        if (busy !== 1'b1 || gain !== 8'hFF || mono !== 3'd0) begin
            errors++;
            $display("FAIL fade_accept: busy=%b gain=%h mono=%0d, want 1 ff 0", busy, gain, mono);
        end
        for (int k = 1; k <= 4; k++) begin
            e = 255 - STEP_I * k;
            if (e < 0) e = 0;
            cyc(1'b1, 1'b0, 1'b0, 3'd0);
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            checks++;
            if (gain !== 8'(e) || mono !== 3'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL fade_out tick %0d: gain=%h mono=%0d busy=%b, want %h 0 1", k, gain, mono, busy, 8'(e));
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (mono !== 3'd1 || gain !== 8'h00) begin
            errors++;
            $display("FAIL fade_switch: mono=%0d gain=%h, want 1 00", mono, gain);
        end
        for (int k = 1; k <= 4; k++) begin
            e = STEP_I * k;
            if (e > 255) e = 255;
            cyc(1'b1, 1'b0, 1'b0, 3'd0);
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            checks++;
            if (gain !== 8'(e) || mono !== 3'd1 || ack !== (k == 4) || busy !== (k != 4)) begin
                errors++;
                $display("FAIL fade_in tick %0d: gain=%h mono=%0d ack=%b busy=%b, want %h 1 %b %b",
                         k, gain, mono, ack, busy, 8'(e), k == 4, k != 4);
            end
        end
        cur = 3'd1;
`else
        cyc(1'b1, 1'b0, 1'b1, 3'd4);
        checks++;
        if (busy !== 1'b1 || mono !== 3'd0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL switch_accept: busy=%b mono=%0d ack=%b, want 1 0 0", busy, mono, ack);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (mono !== 3'd4 || ack !== 1'b1 || busy !== 1'b0 || gain !== 8'hFF) begin
            errors++;
            $display("FAIL switch_tick: mono=%0d ack=%b busy=%b gain=%h, want 4 1 0 ff", mono, ack, busy, gain);
        end
        e = 0;
        cur = 3'd4;
`endif
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (ack !== 1'b0 || mono !== cur || gain !== 8'hFF) begin
            errors++;
            $display("FAIL mode_change_done: ack=%b mono=%0d gain=%h, want 0 %0d ff", ack, mono, gain, cur);
        end
    endtask

    task automatic test_same_mode();
        logic [2:0] nm;
        bit got;
        nm = cur ^ 3'd2;
        cyc(1'b0, 1'b0, 1'b1, cur);
        checks++;
        if (ack !== 1'b1 || busy !== 1'b0 || gain !== 8'hFF || mono !== cur) begin
            errors++;
            $display("FAIL same_mode_ack: ack=%b busy=%b gain=%h mono=%0d, want 1 0 ff %0d", ack, busy, gain, mono, cur);
        end
        cyc(1'b0, 1'b0, 1'b1, nm);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL req_during_ack_parked: ack=%b busy=%b, want 0 0", ack, busy);
        end
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL parked_req_consumed: busy=%b ack=%b, want 1 0", busy, ack);
        end
        run_to_ack(200, got);
        checks++;
        if (got !== 1'b1 || mono !== nm) begin
            errors++;
            $display("FAIL parked_req_done: ack_seen=%b mono=%0d, want 1 %0d", got, mono, nm);
        end
        cur = nm;
    endtask

    task automatic test_pending();
        logic [2:0] first;
        bit got, seen2;
        first = (cur == 3'd5) ? 3'd6 : 3'd5;
        got   = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            cyc(1'b1, (i % 4) == 3, i <= 2, (i == 0) ? first : ((i == 1) ? 3'd2 : 3'd3));
            if (mono == 3'd2) seen2 = 1'b1;
            got = ack;
        end
        checks++;
        if (got !== 1'b1 || mono !== first) begin
            errors++;
            $display("FAIL pending_first_done: ack_seen=%b mono=%0d, want 1 %0d", got, mono, first);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL pending_after_ack: busy=%b ack=%b, want 0 0", busy, ack);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pending_start: busy=%b, want 1", busy);
        end
        run_to_ack(200, got);
        checks++;
        if (got !== 1'b1 || mono !== 3'd3 || seen2 !== 1'b0) begin
            errors++;
            $display("FAIL pending_last_wins: ack_seen=%b mono=%0d saw_mode2=%b, want 1 3 0", got, mono, seen2);
        end
        cur = 3'd3;
    endtask

    task automatic test_ce_gating();
        logic [2:0] m;
        bit got;
        m = cur ^ 3'd4;
        cyc(1'b1, 1'b0, 1'b1, m);
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (gain !== 8'hFF || mono !== cur || ack !== 1'b0) begin
            errors++;
            $display("FAIL ce_gate_no_tick: gain=%h mono=%0d ack=%b, want ff %0d 0", gain, mono, ack, cur);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
`ifdef MONO_SWITCH_FADE_EN
        checks++;
        if (gain !== 8'(255 - STEP_I)) begin
            errors++;
            $display("FAIL ce_gate_tick: gain=%h, want %h", gain, 8'(255 - STEP_I));
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (gain !== 8'(255 - STEP_I)) begin
            errors++;
            $display("FAIL ce_gate_single_tick: gain=%h, want %h", gain, 8'(255 - STEP_I));
        end
        run_to_ack(200, got);
        checks++;
        if (got !== 1'b1 || mono !== m) begin
            errors++;
            $display("FAIL ce_gate_done: ack_seen=%b mono=%0d, want 1 %0d", got, mono, m);
        end
`else
        checks++;
        if (mono !== m || ack !== 1'b1) begin
            errors++;
            $display("FAIL ce_gate_tick: mono=%0d ack=%b, want %0d 1", mono, ack, m);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        got = ack;
        checks++;
        if (got !== 1'b0 || mono !== m) begin
            errors++;
            $display("FAIL ce_gate_single_tick: ack=%b mono=%0d, want 0 %0d", got, mono, m);
        end
`endif
        cur = m;
    endtask

    task automatic test_reset_mid_fade();
        logic [2:0] m;
        bit got;
        m = cur ^ 3'd1;
        cyc(1'b1, 1'b0, 1'b1, m);
`ifdef MONO_SWITCH_FADE_EN
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd0);
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
        end
        checks++;
        if (gain !== 8'h7F || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fade: gain=%h busy=%b, want 7f 1", gain, busy);
        end
`else
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: busy=%b, want 1", busy);
        end
`endif
        ce_pix    = 1'b1;
        VBlank_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mono, gain, busy, ack} !== {3'd0, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_fade: mono=%0d gain=%h busy=%b ack=%b, want 0 ff 0 0", mono, gain, busy, ack);
        end
        @(posedge clk_vid);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 3'd2);
        checks++;
        if (busy !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_accept: busy=%b ack=%b, want 1 0", busy, ack);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (gain !== 8'hFF || mono !== 3'd0 || ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_tick_after_reset: gain=%h mono=%0d ack=%b busy=%b, want ff 0 0 1", gain, mono, ack, busy);
        end
        run_to_ack(200, got);
        checks++;
        if (got !== 1'b1 || mono !== 3'd2) begin
            errors++;
            $display("FAIL post_reset_done: ack_seen=%b mono=%0d, want 1 2", got, mono);
        end
        cur = 3'd2;
    endtask

    // Frame-level reference: phase 0 idle, 1 dimming, 2 swap, 3 brightening, 4 waiting for a frame.
    task automatic test_random();
        int         phase  = 0;
        int         m_gain = 255;
        int         fcnt   = 0;
        logic [2:0] m_mono = 3'd0, m_target = 3'd0, nm, rm;
        logic       m_busy = 1'b0, m_ack = 1'b0, m_prev = 1'b1;
        logic       tk, have, n_ack, c, v, r;
        logic [2:0] pend[$];
        #2 reset = 1'b1;
        @(posedge clk_vid);
        #1 reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            fcnt = (fcnt + 1) % 12;
            v  = (fcnt >= 9);
            c  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 11) == 0);
            rm = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : m_mono;

            tk = c && v && !m_prev;
            if (c) m_prev = v;
            have = 1'b0;
            nm   = rm;
            if (phase == 0 && !m_ack) begin
                if (pend.size() > 0) begin
                    nm   = pend.pop_front();
                    have = 1'b1;
                    if (r) pend.push_back(rm);
                end else if (r) begin
                    have = 1'b1;
                end
            end else if (r) begin
                pend.delete();
                pend.push_back(rm);
            end
            n_ack = 1'b0;
            case (phase)
                0: if (have) begin
                    if (nm == m_mono) n_ack = 1'b1;
                    else begin
                        m_target = nm;
                        m_busy   = 1'b1;
`ifdef MONO_SWITCH_FADE_EN
                        phase    = 1;
`else
                        phase    = 4;
`endif
                    end
                end
                1: if (tk) begin
                    m_gain = m_gain - STEP_I;
                    if (m_gain <= 0) begin m_gain = 0; phase = 2; end
                end
                2: begin m_mono = m_target; phase = 3; end
                3: if (tk) begin
                    m_gain = m_gain + STEP_I;
                    if (m_gain >= 255) begin m_gain = 255; n_ack = 1'b1; m_busy = 1'b0; phase = 0; end
                end
                4: if (tk) begin m_mono = m_target; n_ack = 1'b1; m_busy = 1'b0; phase = 0; end
                default: phase = 0;
            endcase
            m_ack = n_ack;

            cyc(c, v, r, rm);
            checks++;
            if (mono !== m_mono || gain !== 8'(m_gain) || busy !== m_busy || ack !== m_ack) begin
                errors++;
                $display("FAIL random cycle %0d: mono=%0d gain=%h busy=%b ack=%b, want mono=%0d gain=%h busy=%b ack=%b",
                         n, mono, gain, busy, ack, m_mono, 8'(m_gain), m_busy, m_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_same_mode();
        test_pending();
        test_ce_gating();
        test_reset_mid_fade();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
